// File: rtl/imem_loader.sv
// Boot loader: streams a length / payload / checksum byte frame into instruction
// memory while holding the core, then reports done or an error code.
//
// state   | meaning
// S_IDLE  | after reset, nothing loaded, core not held
// S_LEN0  | waiting for length byte N[7:0]
// S_LEN1  | waiting for length byte N[15:8], then length check
// S_DATA  | collecting the 4 little-endian bytes of one word
// S_WRITE | one-cycle imem write of the assembled word
// S_CSUM  | waiting for the checksum byte
// S_DONE  | image loaded and verified, core released
// S_ERR   | load failed, core kept on hold
module imem_loader #(
  parameter int ADDR_W         = 10,
  parameter int MAX_WORDS      = 1024,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]   MAX_LEN   = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [TW-1:0]     idle_q, idle_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              rx_ready_q, rx_ready_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              accept;
  logic              waiting;
  logic [15:0]       len_rx;
  logic [ADDR_W:0]   words_inc;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    csum_d     = csum_q;
    idle_d     = idle_q;
    words_d    = words_q;
    err_code_d = err_code_q;
    accept     = rx_valid && rx_ready_q;
    len_rx     = {rx_data, len_q[7:0]};
    words_inc  = words_q + 1'b1;
    waiting    = state_q inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN0;
          err_code_d = 2'b00;
          words_d    = '0;
          csum_d     = '0;
          byte_cnt_d = '0;
          idle_d     = '0;
        end
      end
      S_LEN0: begin
        if (accept) begin
          len_d[7:0] = rx_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d[15:8] = rx_data;
          if (len_rx == 16'd0 || {1'b0, len_rx} > MAX_LEN) begin
            state_d    = S_ERR;
            err_code_d = 2'b01;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
          csum_d     = csum_q + rx_data;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        words_d = words_inc;
        state_d = (16'(words_inc) == len_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (accept) begin
          if (rx_data == csum_q) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_ERR;
            err_code_d = 2'b10;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // byte-gap watchdog; an accepted byte always wins over expiry
    if (waiting) begin
      if (accept) begin
        idle_d = '0;
      end else if (idle_q == IDLE_LAST) begin
        state_d    = S_ERR;
        err_code_d = 2'b11;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end

    rx_ready_d = state_d inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
    cpu_hold_d = !(state_d inside {S_IDLE, S_DONE});
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_q     <= '0;
      byte_cnt_q <= '0;
      csum_q     <= '0;
      idle_q     <= '0;
      words_q    <= '0;
      rx_ready_q <= 1'b0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      csum_q     <= csum_d;
      idle_q     <= idle_d;
      words_q    <= words_d;
      rx_ready_q <= rx_ready_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  assign imem_we      = (state_q == S_WRITE);
  assign imem_waddr   = imem_we ? words_q[ADDR_W-1:0] : '0;
  assign imem_wdata   = imem_we ? word_q : '0;
  assign rx_ready     = rx_ready_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = err_code_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random frames checked against a
// frame-level model of length, payload words, checksum and byte-gap timeout.
module tb_imem_loader;
  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;
  localparam int TO        = 16;

  typedef logic [7:0] bq_t[$];
  typedef int iq_t[$];

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_loaded;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  int frame_no = 0;
  bit both_seen = 1'b0;

  imem_loader #(
    .ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error), .err_code(err_code),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) wr_count++;
    if (done === 1'b1 && error === 1'b1) both_seen = 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({rx_ready, imem_we, imem_waddr, cpu_hold, done, error, err_code, words_loaded});
  endfunction

  function automatic logic [7:0] payload_sum(bq_t b);
    int n;
    logic [7:0] s;
    n = int'({b[1], b[0]});
    s = 8'h00;
    for (int k = 2; k < 2 + 4 * n && k < b.size(); k++) s += b[k];
    return s;
  endfunction

  function automatic bq_t rand_frame(int nw, bit bad);
    bq_t b;
    b.push_back(8'(nw));
    b.push_back(8'(nw >> 8));
    for (int k = 0; k < 4 * nw; k++) b.push_back(8'($urandom));
    b.push_back(payload_sum(b) + (bad ? 8'($urandom_range(1, 255)) : 8'h00));
    return b;
  endfunction

  function automatic iq_t flat_gaps(int n, int v);
    iq_t g;
    for (int k = 0; k < n; k++) g.push_back(v);
    return g;
  endfunction

  // All tasks start and end at a negedge.
  task automatic do_start(input bit with_valid);
    start = 1'b1;
    if (with_valid) begin
      rx_valid = 1'b1;
      rx_data  = 8'hFF;
    end
    @(negedge clk);
    start    = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Returns at the negedge just after the accepting posedge (the WRITE cycle
  // when this was the 4th byte of a word); ok=0 if never offered.
  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    ok = 1'b0;
    wait_ready();
    repeat (gap) @(negedge clk);
    if (rx_ready === 1'b1) begin
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
      ok = 1'b1;
    end
  endtask

  task automatic run_frame(input bq_t b, input iq_t g, input bit start_with_valid,
                           input int mid_start_idx);
    logic [31:0] ew[$];
    int nf, exp_err, last, to_idx, widx, wr0;
    bit exp_done, ok;
    logic [7:0] sum;
    string p;

    nf       = int'({b[1], b[0]});
    sum      = payload_sum(b);
    exp_err  = 0;
    exp_done = 1'b0;
    last     = -1;
    to_idx   = -1;
    for (int i = 0; i < b.size(); i++) begin
      if (g[i] >= TO) begin
        exp_err = 3;
        to_idx  = i;
        break;
      end
      last = i;
      if (i == 1 && (nf == 0 || nf > MAX_WORDS)) begin
        exp_err = 1;
        break;
      end
      if (i >= 5 && i < 2 + 4 * nf && (i - 2) % 4 == 3)
        ew.push_back({b[i], b[i-1], b[i-2], b[i-3]});
      if (i == 2 + 4 * nf) begin
        if (b[i] == sum) exp_done = 1'b1;
        else exp_err = 2;
        break;
      end
    end

    frame_no++;
    p = $sformatf("f%0d", frame_no);
    wr0 = wr_count;
    both_seen = 1'b0;
    do_start(start_with_valid);
    chk({p, " start_hold"}, 32'(cpu_hold), 32'd1);
    chk({p, " start_flags"}, 32'({done, error, err_code, words_loaded}), 32'd0);

    widx = 0;
    for (int i = 0; i <= last; i++) begin
      if (i == mid_start_idx) begin
        wait_ready();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      send_byte(b[i], g[i], ok);
      chk($sformatf("%s accept%0d", p, i), 32'(ok), 32'd1);
      if (i >= 5 && i < 2 + 4 * nf && (i - 2) % 4 == 3) begin
        chk($sformatf("%s we%0d", p, widx), 32'(imem_we), 32'd1);
        chk($sformatf("%s waddr%0d", p, widx), 32'(imem_waddr), 32'(widx));
        chk($sformatf("%s wdata%0d", p, widx), imem_wdata, ew[widx]);
        widx++;
      end
    end
    if (to_idx >= 0) begin
      send_byte(b[to_idx], g[to_idx], ok);
      chk({p, " timeout_blocks_byte"}, 32'(ok), 32'd0);
    end
    @(negedge clk);
    chk({p, " done"}, 32'(done), 32'(exp_done));
    chk({p, " error"}, 32'(error), 32'(exp_err != 0));
    chk({p, " err_code"}, 32'(err_code), 32'(exp_err));
    chk({p, " cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
    chk({p, " words_loaded"}, 32'(words_loaded), 32'(ew.size()));
    chk({p, " rx_ready_off"}, 32'(rx_ready), 32'd0);
    chk({p, " write_count"}, 32'(wr_count - wr0), 32'(ew.size()));
    chk({p, " done_err_excl"}, 32'(both_seen), 32'd0);
  endtask

  initial begin
    bq_t f2, f1, fb;
    iq_t g;
    bit ok;
    int wr0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("idle_outs", out_vec(), 32'd0);
    end
    chk("idle_wdata", imem_wdata, 32'd0);
    chk("idle_writes", 32'(wr_count), 32'd0);

    f2 = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    f2.push_back(payload_sum(f2));
    run_frame(f2, flat_gaps(f2.size(), 0), 1'b0, -1);

    fb = f2;
    fb[10] = 8'h3A;
    run_frame(fb, flat_gaps(fb.size(), 0), 1'b0, -1);
    fb[10] = f2[10] + 8'h01;
    run_frame(fb, flat_gaps(fb.size(), 0), 1'b0, -1);

    run_frame('{8'h00, 8'h00}, flat_gaps(2, 0), 1'b0, -1);
    run_frame('{8'h01, 8'h04}, flat_gaps(2, 0), 1'b0, -1);

    run_frame(f2, flat_gaps(f2.size(), 10), 1'b0, -1);
    g = flat_gaps(f2.size(), 0);
    g[5] = 16;
    run_frame(f2, g, 1'b0, -1);
    g[5] = 15;
    run_frame(f2, g, 1'b1, -1);

    // abort in the middle of the second word, then reload
    do_start(1'b0);
    for (int i = 0; i < 8; i++) send_byte(f2[i], 0, ok);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_outs", out_vec(), 32'd0);
    chk("midrst_wdata", imem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    f1 = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    f1.push_back(payload_sum(f1));
    run_frame(f1, flat_gaps(f1.size(), 0), 1'b0, 3);

    for (int r = 0; r < 24; r++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0:       fb = '{8'h00, 8'h00};
          1:       fb = '{8'h01, 8'h04};
          default: fb = '{8'hFF, 8'hFF};
        endcase
      end else begin
        fb = rand_frame($urandom_range(1, 6), $urandom_range(0, 3) == 0);
      end
      g = '{};
      for (int k = 0; k < fb.size(); k++) g.push_back($urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) g[$urandom_range(0, fb.size() - 1)] = $urandom_range(13, 18);
      run_frame(fb, g, $urandom_range(0, 1) == 1, -1);
    end

    wr0 = wr_count;
    fb = rand_frame(MAX_WORDS, 1'b0);
    run_frame(fb, flat_gaps(fb.size(), 0), 1'b0, -1);
    chk("max_image_writes", 32'(wr_count - wr0), 32'(MAX_WORDS));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
